// File: rtl/hub75_scan_scheduler.sv
// HUB75 refresh sequencer: walks row address and bit-plane, requests each row shift, then
// blanks, latches and lights the row for a binary-weighted (BCM) on-time.
module hub75_scan_scheduler #(
  parameter int SCAN_RATE      = 32,
  parameter int NUM_BITPLANES  = 3,
  parameter int BASE_ON_CYCLES = 64,
  parameter int BLANK_CYCLES   = 4,
  localparam int ROW_W   = (SCAN_RATE > 1) ? $clog2(SCAN_RATE) : 1,
  localparam int PLANE_W = (NUM_BITPLANES > 1) ? $clog2(NUM_BITPLANES) : 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable,
  input  logic               shift_done,
  output logic [ROW_W-1:0]   row_addr,
  output logic [PLANE_W-1:0] bitplane,
  output logic               shift_req,
  output logic               latch,
  output logic               oe_n,
  output logic               frame_done,
  output logic               busy
);

  localparam int DISP_W  = $clog2(BASE_ON_CYCLES << (NUM_BITPLANES - 1)) + 1;
  localparam int BLANK_W = $clog2(BLANK_CYCLES) + 1;
  localparam int CNT_W   = (DISP_W > BLANK_W) ? DISP_W : BLANK_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_BLANK   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_DISPLAY = 3'd4;

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(SCAN_RATE - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(NUM_BITPLANES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] on_last;

  // Last count value of the lit phase for the current plane (BCM weight minus one).
  assign on_last = (CNT_W'(BASE_ON_CYCLES) << bitplane) - 1'b1;

  // DISPLAY has two phases told apart by oe_n: the lit run, then a single dark
  // cycle in which row/plane advance and frame_done pulses at the end of a frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      row_addr   <= '0;
      bitplane   <= '0;
      shift_req  <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_SHIFT;
            shift_req <= 1'b1;
            busy      <= 1'b1;
            row_addr  <= '0;
            bitplane  <= '0;
          end
        end
        S_SHIFT: begin
          if (shift_done) begin
            state     <= S_BLANK;
            shift_req <= 1'b0;
            cnt       <= '0;
          end
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= S_LATCH;
            latch <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: begin
          state <= S_DISPLAY;
          latch <= 1'b0;
          oe_n  <= 1'b0;
          cnt   <= '0;
        end
        S_DISPLAY: begin
          if (!oe_n) begin
            if (cnt == on_last) begin
              oe_n <= 1'b1;
              cnt  <= '0;
              if (bitplane != LAST_PLANE) begin
                bitplane <= bitplane + 1'b1;
              end else begin
                bitplane <= '0;
                if (row_addr != LAST_ROW) begin
                  row_addr <= row_addr + 1'b1;
                end else begin
                  row_addr   <= '0;
                  frame_done <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (frame_done && !enable) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state     <= S_SHIFT;
            shift_req <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          shift_req <= 1'b0;
          latch     <= 1'b0;
          oe_n      <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Self-checking bench for hub75_scan_scheduler: randomized shifter acknowledge delays against
// a plane-schedule model built from row/plane loops and BCM weights.
module tb_hub75_scan_scheduler;

  localparam int SCAN_RATE      = 4;
  localparam int NUM_BITPLANES  = 2;
  localparam int BASE_ON_CYCLES = 4;
  localparam int BLANK_CYCLES   = 2;
  localparam int ROW_W   = $clog2(SCAN_RATE);
  localparam int PLANE_W = $clog2(NUM_BITPLANES);

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               enable = 1'b0;
  logic               shift_done = 1'b0;
  logic [ROW_W-1:0]   row_addr;
  logic [PLANE_W-1:0] bitplane;
  logic               shift_req;
  logic               latch;
  logic               oe_n;
  logic               frame_done;
  logic               busy;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  plane;
    logic [7:0]  blank;
    logic [7:0]  latch;
    logic [15:0] on;
    logic [7:0]  bad;
    logic        fd;
    logic        tout;
  } plane_obs_t;

  typedef struct {
    int r;
    int p;
  } slot_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_start = 0;
  int    mon_bad = 0;
  int    fd_count = 0;
  slot_t sched[$];

  hub75_scan_scheduler #(
    .SCAN_RATE(SCAN_RATE),
    .NUM_BITPLANES(NUM_BITPLANES),
    .BASE_ON_CYCLES(BASE_ON_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .enable(enable),
    .shift_done(shift_done),
    .row_addr(row_addr),
    .bitplane(bitplane),
    .shift_req(shift_req),
    .latch(latch),
    .oe_n(oe_n),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Continuous safety properties, sampled on the falling edge.
  logic               prev_rst = 1'b1;
  logic               prev_fd = 1'b0;
  logic [ROW_W-1:0]   prev_row = '0;
  logic [PLANE_W-1:0] prev_plane = '0;
  always @(negedge clk_in) begin
    if (!rst_in && !prev_rst) begin
      if (latch && !oe_n) begin
        mon_bad++;
        $display("[TB] monitor: latch high while row lit at %0t", $time);
      end
      if ((!oe_n || shift_req) && (row_addr !== prev_row || bitplane !== prev_plane)) begin
        mon_bad++;
        $display("[TB] monitor: address moved while lit or shifting at %0t", $time);
      end
      if (frame_done && (prev_fd || row_addr !== '0 || bitplane !== '0 || !oe_n || shift_req)) begin
        mon_bad++;
        $display("[TB] monitor: malformed frame_done at %0t", $time);
      end
      if (frame_done) fd_count++;
    end
    prev_rst   = rst_in;
    prev_fd    = frame_done;
    prev_row   = row_addr;
    prev_plane = bitplane;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic en);
    rst_in     = 1'b1;
    shift_done = 1'b0;
    enable     = en;
    repeat (2) tick();
    rst_in = 1'b0;
  endtask

  function automatic void build_sched();
    sched.delete();
    for (int r = 0; r < SCAN_RATE; r++)
      for (int p = 0; p < NUM_BITPLANES; p++)
        sched.push_back('{r: r, p: p});
  endfunction

  function automatic plane_obs_t model_plane(input int r, input int p);
    plane_obs_t m;
    m.row   = 8'(r);
    m.plane = 8'(p);
    m.blank = 8'(BLANK_CYCLES);
    m.latch = 8'd1;
    m.on    = 16'(BASE_ON_CYCLES << p);
    m.bad   = 8'd0;
    m.fd    = (r == SCAN_RATE - 1) && (p == NUM_BITPLANES - 1);
    m.tout  = 1'b0;
    return m;
  endfunction

  // Acts as the shifter for one plane and measures every phase; returns on the dark advance cycle.
  task automatic do_plane(input int delay, input bit stray, output plane_obs_t o);
    int guard;
    o = '0;
    guard = 0;
    while (shift_req !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (shift_req !== 1'b1) begin
      o.tout = 1'b1;
      return;
    end
    last_start = cyc;
    o.row   = 8'(row_addr);
    o.plane = 8'(bitplane);
    for (int i = 0; i <= delay; i++) begin
      if (shift_req !== 1'b1 || oe_n !== 1'b1 || latch !== 1'b0) o.bad++;
      if (i < delay) tick();
    end
    shift_done = 1'b1;
    tick();
    shift_done = 1'b0;
    guard = 0;
    while (latch !== 1'b1 && guard < 50) begin
      if (oe_n === 1'b1 && shift_req === 1'b0) o.blank++;
      else o.bad++;
      shift_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    while (latch === 1'b1 && guard < 60) begin
      o.latch++;
      if (oe_n !== 1'b1) o.bad++;
      shift_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    guard = 0;
    while (oe_n === 1'b0 && guard < 600) begin
      o.on++;
      if (8'(row_addr) !== o.row || 8'(bitplane) !== o.plane || latch !== 1'b0) o.bad++;
      shift_done = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      guard++;
    end
    shift_done = 1'b0;
    if (guard >= 600) o.tout = 1'b1;
    o.fd = frame_done;
    if (shift_req !== 1'b0 || latch !== 1'b0 || oe_n !== 1'b1) o.bad++;
  endtask

  task automatic test_reset();
    int guard;
    int idle_bad;
    do_reset(1'b0);
    checks++;
    if (row_addr !== '0 || bitplane !== '0 || shift_req !== 1'b0 || latch !== 1'b0 ||
        oe_n !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: row=%0d plane=%0d req=%b lat=%b oe_n=%b fd=%b busy=%b, required 0 0 0 0 1 0 0",
               row_addr, bitplane, shift_req, latch, oe_n, frame_done, busy);
    end
    idle_bad = 0;
    repeat (30) begin
      tick();
      if (busy !== 1'b0 || shift_req !== 1'b0 || oe_n !== 1'b1) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("[TB] FAIL idle_hold: %0d non-idle cycles, required 0", idle_bad);
    end
    enable = 1'b1;
    guard = 0;
    while (!(row_addr == ROW_W'(1) && oe_n === 1'b0) && guard < 400) begin
      shift_done = shift_req;
      tick();
      guard++;
    end
    shift_done = 1'b0;
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("[TB] FAIL reach_row1_display: timed out after %0d cycles, required < 400", guard);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (oe_n !== 1'b1 || latch !== 1'b0 || shift_req !== 1'b0 || row_addr !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: oe_n=%b lat=%b req=%b row=%0d busy=%b, required 1 0 0 0 0",
               oe_n, latch, shift_req, row_addr, busy);
    end
    enable = 1'b0;
    repeat (2) tick();
    rst_in = 1'b0;
    idle_bad = 0;
    repeat (40) begin
      tick();
      if (busy !== 1'b0 || shift_req !== 1'b0 || oe_n !== 1'b1 || latch !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: %0d non-idle cycles, required 0", idle_bad);
    end
  endtask

  task automatic test_single_plane();
    plane_obs_t o;
    plane_obs_t e;
    int s0;
    int expected_period;
    do_reset(1'b1);
    do_plane(3, 1'b0, o);
    e = model_plane(0, 0);
    s0 = last_start;
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL single_plane0: got %h, required %h", o, e);
    end
    do_plane(3, 1'b0, o);
    e = model_plane(0, 1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL single_plane1: got %h, required %h", o, e);
    end
    expected_period = (3 + 1) + 1 + BLANK_CYCLES + 1 + BASE_ON_CYCLES;
    checks++;
    if (last_start - s0 !== expected_period) begin
      errors++;
      $display("[TB] FAIL plane_period: got %0d cycles, required %0d", last_start - s0, expected_period);
    end
  endtask

  task automatic test_full_frame();
    plane_obs_t o;
    plane_obs_t e;
    int fd0;
    build_sched();
    do_reset(1'b1);
    fd0 = fd_count;
    for (int f = 0; f < 2; f++) begin
      foreach (sched[i]) begin
        do_plane(int'($urandom_range(0, 4)), 1'b1, o);
        e = model_plane(sched[i].r, sched[i].p);
        checks++;
        if (o !== e) begin
          errors++;
          $display("[TB] FAIL full_frame f%0d r%0d p%0d: got %h, required %h", f, sched[i].r, sched[i].p, o, e);
        end
      end
      tick();
      checks++;
      if (shift_req !== 1'b1 || row_addr !== '0 || bitplane !== '0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL frame_restart f%0d: req=%b row=%0d plane=%0d busy=%b, required 1 0 0 1",
                 f, shift_req, row_addr, bitplane, busy);
      end
    end
    checks++;
    if (fd_count - fd0 !== 2) begin
      errors++;
      $display("[TB] FAIL frame_done_count: got %0d pulses, required 2", fd_count - fd0);
    end
  endtask

  task automatic test_stall();
    plane_obs_t o;
    plane_obs_t e;
    do_reset(1'b1);
    do_plane(100, 1'b1, o);
    e = model_plane(0, 0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL stall_plane0: got %h, required %h", o, e);
    end
    do_plane(int'($urandom_range(0, 3)), 1'b1, o);
    e = model_plane(0, 1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL stall_plane1: got %h, required %h", o, e);
    end
  endtask

  task automatic test_enable_drop();
    plane_obs_t o;
    plane_obs_t e;
    int fd0;
    int idle_bad;
    build_sched();
    do_reset(1'b1);
    fd0 = fd_count;
    foreach (sched[i]) begin
      do_plane(int'($urandom_range(0, 4)), 1'b0, o);
      e = model_plane(sched[i].r, sched[i].p);
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL enable_drop r%0d p%0d: got %h, required %h", sched[i].r, sched[i].p, o, e);
      end
      if (sched[i].r == 1 && sched[i].p == 0) enable = 1'b0;
    end
    tick();
    idle_bad = 0;
    repeat (20) begin
      if (busy !== 1'b0 || shift_req !== 1'b0 || oe_n !== 1'b1) idle_bad++;
      tick();
    end
    checks++;
    if (idle_bad !== 0 || fd_count - fd0 !== 1) begin
      errors++;
      $display("[TB] FAIL enable_drop_idle: %0d non-idle cycles, %0d frame_done, required 0 and 1",
               idle_bad, fd_count - fd0);
    end
  endtask

  task automatic test_monitor();
    checks++;
    if (mon_bad !== 0) begin
      errors++;
      $display("[TB] FAIL safety_monitor: %0d property violations, required 0", mon_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_plane();
    test_full_frame();
    test_stall();
    test_enable_drop();
    test_monitor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
